// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the pipelined immediate generator (imm_gen_pipe).
// Optional feature macro: IMM_ILLEGAL_FLAG_EN.
package imm_pkg;

   localparam int INSTR_WIDTH = 32;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_I5   = 3'd5,
      IMM_Z    = 3'd6,
      IMM_RSVD = 3'd7
   } imm_src_t;

   // Occupancy of the output/skid pair
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

endpackage

// File: rtl/imm_gen_pipe_compose.sv
// Combinational immediate format mux feeding the imm_gen_pipe elastic buffer.
// With IMM_ILLEGAL_FLAG_EN defined it also flags the reserved format code.
module imm_compose
   import imm_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [INSTR_WIDTH-1:0] instr,
   input  imm_src_t               imm_src,
   output logic [DATA_WIDTH-1:0]  imm
`ifdef IMM_ILLEGAL_FLAG_EN
   ,
   output logic                   illegal
`endif
);

   // Opcode bits never contribute to an immediate
   logic unused_opcode_s;
   assign unused_opcode_s = ^instr[6:0];

   // Format select; size casts of signed operands perform the sign extension
   always_comb begin
      imm = '0;
      case (imm_src)
         IMM_I:  imm = DATA_WIDTH'($signed(instr[31:20]));
         IMM_S:  imm = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
         IMM_B:  imm = DATA_WIDTH'($signed({instr[31], instr[7], instr[30:25],
                                            instr[11:8], 1'b0}));
         IMM_U:  imm = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
         IMM_J:  imm = DATA_WIDTH'($signed({instr[31], instr[19:12], instr[20],
                                            instr[30:21], 1'b0}));
         IMM_I5: begin
            if (DATA_WIDTH == 64) begin
               imm = DATA_WIDTH'(instr[25:20]);
            end else begin
               imm = DATA_WIDTH'(instr[24:20]);
            end
         end
         IMM_Z:  imm = DATA_WIDTH'(instr[19:15]);
         default: imm = '0;
      endcase
   end

`ifdef IMM_ILLEGAL_FLAG_EN
   assign illegal = (imm_src == IMM_RSVD);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry elastic (skid) output buffer.
// Define IMM_ILLEGAL_FLAG_EN to add the out_illegal sideband output.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  imm_src_t               imm_src,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_imm,
   output logic [TAG_WIDTH-1:0]   out_tag
`ifdef IMM_ILLEGAL_FLAG_EN
   ,
   output logic                   out_illegal
`endif
);

   // Entry widths follow the module parameters, so the entry type is local
   typedef struct packed {
      logic [DATA_WIDTH-1:0] imm;
      logic [TAG_WIDTH-1:0]  tag;
`ifdef IMM_ILLEGAL_FLAG_EN
      logic                  illegal;
`endif
   } imm_entry_t;

   logic [DATA_WIDTH-1:0] imm_s;
   imm_entry_t            new_s;
   imm_entry_t            o_r;
   imm_entry_t            s_r;
   buf_state_t            state_r;
   logic                  out_valid_r;
   logic                  in_ready_r;
   logic                  in_xfer_s;
   logic                  out_xfer_s;

`ifdef IMM_ILLEGAL_FLAG_EN
   logic illegal_s;

   imm_compose #(.DATA_WIDTH(DATA_WIDTH)) u_compose (
      .instr   (instr),
      .imm_src (imm_src),
      .imm     (imm_s),
      .illegal (illegal_s)
   );
`else
   imm_compose #(.DATA_WIDTH(DATA_WIDTH)) u_compose (
      .instr   (instr),
      .imm_src (imm_src),
      .imm     (imm_s)
   );
`endif

   // Incoming entry assembled from the composed immediate and the sideband
   always_comb begin
      new_s     = '0;
      new_s.imm = imm_s;
      new_s.tag = in_tag;
`ifdef IMM_ILLEGAL_FLAG_EN
      new_s.illegal = illegal_s;
`endif
   end

   assign in_xfer_s  = in_valid && in_ready_r;
   assign out_xfer_s = out_valid_r && out_ready;

   // Elastic buffer control: O is the output register, S the skid register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= BUF_EMPTY;
         o_r         <= '0;
         s_r         <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else if (flush) begin
         state_r     <= BUF_EMPTY;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         case (state_r)
            BUF_EMPTY: begin
               if (in_xfer_s) begin
                  o_r         <= new_s;
                  out_valid_r <= 1'b1;
                  state_r     <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (in_xfer_s && out_xfer_s) begin
                  o_r <= new_s;
               end else if (in_xfer_s) begin
                  s_r        <= new_s;
                  in_ready_r <= 1'b0;
                  state_r    <= BUF_TWO;
               end else if (out_xfer_s) begin
                  out_valid_r <= 1'b0;
                  state_r     <= BUF_EMPTY;
               end
            end
            // in_ready is low here, so S always drains before new input lands
            BUF_TWO: begin
               if (out_xfer_s) begin
                  o_r        <= s_r;
                  in_ready_r <= 1'b1;
                  state_r    <= BUF_ONE;
               end
            end
            default: begin
               state_r     <= BUF_EMPTY;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_imm   = o_r.imm;
   assign out_tag   = o_r.tag;
`ifdef IMM_ILLEGAL_FLAG_EN
   assign out_illegal = o_r.illegal;
`endif

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It accepts an instruction word, an immediate-format select and a sideband tag (typically the PC) over a valid/ready handshake. It composes the immediate and presents it on a registered valid/ready output. It sits between fetch/decode and execute in pipelined core variants and absorbs back-pressure with a 2-entry elastic (skid) buffer.

Parameters:
- DATA_WIDTH, 32, immediate/output width; legal values 32 or 64; instruction input is always 32 bits.
- TAG_WIDTH, 32, width of the opaque sideband tag carried alongside each immediate; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronously discard all buffered entries.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  instruction word.
- imm_src  in  3  immediate format select, imm_src_t.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  out_imm and out_tag are valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  DATA_WIDTH  composed immediate.
- out_tag  out  TAG_WIDTH  tag of the entry on out_imm.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_imm=0, out_tag=0, skid buffer empty, in_ready=1 in the cycle after reset.
- Formats, sign bit instr[31], extended to DATA_WIDTH:
  - I: instr[31:20], sign-extended.
  - S: {instr[31:25], instr[11:7]}, sign-extended.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U: {instr[31:12], 12'b0}, sign-extended above bit 31 when DATA_WIDTH=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - I5 (shamt): instr[24:20], zero-extended; instr[25] is also included when DATA_WIDTH=64.
  - Z (CSR uimm): instr[19:15], zero-extended.
  - Code 7: reserved, immediate is 0.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready is a registered signal equal to "skid buffer empty"; it has no combinational path from out_ready.
- Latency and throughput: 1 cycle from input transfer to out_valid when the output stage is empty or draining. Sustained throughput is 1 per cycle while out_ready=1.
- Storage: output register (stage O) plus skid register (stage S). Together they form the states EMPTY, ONE (O full) and TWO (O and S full).
- Transitions:
  - EMPTY with input -> ONE.
  - ONE with input and output transfer -> ONE; O reloads from the input.
  - ONE with input and no output transfer -> TWO; the input is captured in S.
  - ONE with output transfer and no input -> EMPTY.
  - TWO with output transfer -> ONE; S moves to O, and no input is accepted since in_ready=0.
  - TWO with no output transfer -> hold.
- Ordering: entries leave strictly in arrival order. When a stall releases, S moves to O before any new input is accepted.
- Stall stability: while out_valid && !out_ready, out_imm and out_tag hold stable.
- flush: next state EMPTY and out_valid=0. Any input presented in the flush cycle is dropped and not transferred, even if in_ready=1.
- Priority: rst over flush, and flush over all transfers.
- Reset mid-operation: all entries are discarded and outputs return to their reset values, with no partial transfer.
- Datapath: the immediate is computed combinationally on the input side and registered; it is not recomputed in O.

Optional Feature:
- IMM_ILLEGAL_FLAG_EN defined:
  - Adds output out_illegal (1 bit), registered with and carried alongside each entry.
  - out_illegal=1 when imm_src=7; out_imm is 0 in that case.
  - The reset value of out_illegal is 0.
- Undefined: no out_illegal port. Code 7 silently yields 0.
- In neither configuration does the block emit a $display.

Decomposition:
- Package imm_pkg:
  - typedef enum logic [2:0] imm_src_t with IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_I5=5, IMM_Z=6, IMM_RSVD=7.
  - Localparam INSTR_WIDTH=32.
  - Packed struct imm_entry_t {imm, tag, illegal} shared by stages O and S.
- One sub-module, imm_compose: a purely combinational format mux (instr, imm_src -> imm, illegal). imm_gen_pipe instantiates it once and implements the elastic buffer.

Test Plan:
- Format sweep, out_ready=1 held, one instruction per cycle:
  - 0xFFF00093 with I -> 0xFFFFFFFF.
  - 0xFE112E23 with S -> 0xFFFFFFFC.
  - 0x123450B7 with U -> 0x12345000.
  - 0x001000EF with J -> 0x00000800.
  - Each appears exactly 1 cycle after acceptance, in order.
- Back-pressure: drop out_ready while sending 3 back-to-back inputs.
  - in_ready=0 after the second input is accepted.
  - out_imm and out_tag stay stable during the stall.
  - After out_ready returns, all 3 tags emerge in order with no duplicates or loss.
- Random valid/ready over 10k cycles against a scoreboard model: every input transfer appears once at the output, in order, with the correct immediate.
- Flush with TWO entries buffered and in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed tags and the dropped input never appear.
- DATA_WIDTH=64 build:
  - 0x80000037 with U -> 0xFFFFFFFF80000000.
  - 0x03F00013 with I5 -> 0x000000000000003F.
- IMM_ILLEGAL_FLAG_EN build: imm_src=7 -> out_illegal=1 and out_imm=0; the next valid I-format entry shows out_illegal=0. Assert rst mid-stream -> all outputs are 0 on the next cycle.
